wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_pkg.sv | 22 ++
 rtl/pipe_skid_buf.sv | 84 ++++++++
 rtl/wb_pipe_stage.sv | 111 +++++++++++
 tb/tb_wb_pipe_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pipe_pkg.sv
// rtl/wb_pipe_pkg.sv - shared widths, payload type and helpers for the write-back pipe stage
package wb_pipe_pkg;

    localparam int WB_DATA_W_DEF = 32;
    localparam int WB_DEST_W_DEF = 4;
    localparam int WB_CNT_W_DEF  = 32;

    // Payload carried through the stage at the default widths.
    typedef struct packed {
        logic                     mem_r_en;
        logic                     wb_en;
        logic [WB_DATA_W_DEF-1:0] alu_res;
        logic [WB_DATA_W_DEF-1:0] mem_data;
        logic [WB_DEST_W_DEF-1:0] dest;
    } wb_payload_t;

    // Packed payload width for arbitrary data/dest widths.
    function automatic int payload_w(input int data_w, input int dest_w);
        return 2 + 2 * data_w + dest_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic two-entry skid register (main + skid) with synchronous clear
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               drop both entries at the next edge (wins over everything)
//   in_valid/in_ready   upstream handshake; in_ready is registered (= !skid_valid)
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake, driven from the main entry
//   out_data [W]        main entry payload
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q,   in_ready_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic [W-1:0] skid_data_q,  skid_data_d;

    logic in_hs;
    logic main_free;

    assign in_hs     = in_valid && in_ready_q;
    // Main can take a new entry this edge if it is empty or handing off.
    assign main_free = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (clear) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is full, so no input can collide here.
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_hs) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_hs) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - write-back pipeline stage with skid buffering, flush and write-back mux
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         discard held and incoming entries
//   in_valid/in_ready             upstream handshake (in_ready registered)
//   in_mem_r_en, in_wb_en,
//   in_alu_res, in_mem_data,
//   in_dest                       upstream payload
//   out_valid/out_ready           downstream handshake
//   out_mem_r_en, out_alu_res,
//   out_mem_data, out_dest        registered payload of the head entry
//   out_wb_en                     stored wb_en gated by out_valid
//   out_wb_value                  mem_data if mem_r_en else alu_res
//   stall_cnt [CNT_W]             saturating stall counter, only with WB_PIPE_PERF_EN defined
module wb_pipe_stage
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W_DEF,
    parameter int DEST_W = WB_DEST_W_DEF,
    parameter int CNT_W  = WB_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_r_en,
    input  logic              in_wb_en,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DEST_W-1:0] in_dest,
`ifdef WB_PIPE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mem_r_en,
    output logic              out_wb_en,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_wb_value
);

    localparam int PAY_W = payload_w(DATA_W, DEST_W);

    typedef struct packed {
        logic              mem_r_en;
        logic              wb_en;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem_data;
        logic [DEST_W-1:0] dest;
    } payload_t;

    payload_t in_pay;
    payload_t out_pay;
    logic     buf_in_valid;

    assign in_pay = '{mem_r_en: in_mem_r_en, wb_en: in_wb_en, alu_res: in_alu_res,
                      mem_data: in_mem_data, dest: in_dest};

    // A flushed cycle never counts as an input handshake.
    assign buf_in_valid = in_valid && !flush;

    pipe_skid_buf #(
        .W(PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .in_valid  (buf_in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign out_mem_r_en = out_pay.mem_r_en;
    assign out_alu_res  = out_pay.alu_res;
    assign out_mem_data = out_pay.mem_data;
    assign out_dest     = out_pay.dest;
    assign out_wb_en    = out_pay.wb_en && out_valid;
    assign out_wb_value = out_pay.mem_r_en ? out_pay.mem_data : out_pay.alu_res;

`ifdef WB_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts head-of-line stalls; flush does not touch it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - directed self-checking bench for wb_pipe_stage
module tb_wb_pipe_stage;

    localparam int DATA_W = 32;
    localparam int DEST_W = 4;
`ifdef WB_PIPE_PERF_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_mem_r_en = 1'b0;
    logic              in_wb_en = 1'b0;
    logic [DATA_W-1:0] in_alu_res = '0;
    logic [DATA_W-1:0] in_mem_data = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_mem_r_en;
    logic              out_wb_en;
    logic [DATA_W-1:0] out_alu_res;
    logic [DATA_W-1:0] out_mem_data;
    logic [DEST_W-1:0] out_dest;
    logic [DATA_W-1:0] out_wb_value;
`ifdef WB_PIPE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pipe_stage #(
        .DATA_W(DATA_W),
        .DEST_W(DEST_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mem_r_en (in_mem_r_en),
        .in_wb_en    (in_wb_en),
        .in_alu_res  (in_alu_res),
        .in_mem_data (in_mem_data),
        .in_dest     (in_dest),
`ifdef WB_PIPE_PERF_EN
        .stall_cnt   (stall_cnt),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_mem_r_en(out_mem_r_en),
        .out_wb_en   (out_wb_en),
        .out_alu_res (out_alu_res),
        .out_mem_data(out_mem_data),
        .out_dest    (out_dest),
        .out_wb_value(out_wb_value)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic mr, input logic wb,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] md,
                         input logic [DEST_W-1:0] dst);
        in_valid    = v;
        in_mem_r_en = mr;
        in_wb_en    = wb;
        in_alu_res  = alu;
        in_mem_data = md;
        in_dest     = dst;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_wb_en", 64'(out_wb_en), 64'd0);
        chk("rst_alu_res", 64'(out_alu_res), 64'd0);
        chk("rst_wb_value", 64'(out_wb_value), 64'd0);
        chk("rst_dest", 64'(out_dest), 64'd0);
`ifdef WB_PIPE_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

        // Streaming with out_ready held high
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'd1);
        step();
        chk("stream0_valid", 64'(out_valid), 64'd1);
        chk("stream0_alu", 64'(out_alu_res), 64'h10);
        chk("stream0_wb_en", 64'(out_wb_en), 64'd1);
        chk("stream0_dest", 64'(out_dest), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 4'd2);
        step();
        chk("stream1_valid", 64'(out_valid), 64'd1);
        chk("stream1_alu", 64'(out_alu_res), 64'h11);
        chk("stream1_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h12, 32'h0, 4'd3);
        step();
        chk("stream2_valid", 64'(out_valid), 64'd1);
        chk("stream2_alu", 64'(out_alu_res), 64'h12);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();
        chk("stream_drained_valid", 64'(out_valid), 64'd0);
        chk("stream_drained_wb_en", 64'(out_wb_en), 64'd0);

        // Back-pressure: A in main, B in skid
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 4'd4);
        step();
        chk("bp_a_alu", 64'(out_alu_res), 64'h20);
        chk("bp_a_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 32'h21, 32'h0, 4'd5);
        step();
        chk("bp_b_in_ready", 64'(in_ready), 64'd0);
        chk("bp_b_head_still_a", 64'(out_alu_res), 64'h20);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        step();
        chk("bp_hold_alu", 64'(out_alu_res), 64'h20);
        chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_alu", 64'(out_alu_res), 64'h21);
        chk("bp_b_dest", 64'(out_dest), 64'd5);
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 4'd6);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h31, 32'h0, 4'd7);
        step();
        chk("fl_full_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'd8);
        step();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_wb_en", 64'(out_wb_en), 64'd0);
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        out_ready = 1'b1;
        step();
        chk("fl_input_dropped", 64'(out_valid), 64'd0);

        // Write-back value mux
        drive(1'b1, 1'b1, 1'b1, 32'hBEEF, 32'hDEAD, 4'd9);
        step();
        chk("mux_mem_value", 64'(out_wb_value), 64'hDEAD);
        chk("mux_mem_r_en", 64'(out_mem_r_en), 64'd1);
        chk("mux_mem_data", 64'(out_mem_data), 64'hDEAD);
        drive(1'b1, 1'b0, 1'b1, 32'hBEEF, 32'hDEAD, 4'd10);
        step();
        chk("mux_alu_value", 64'(out_wb_value), 64'hBEEF);
        chk("mux_alu_wb_en", 64'(out_wb_en), 64'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 4'd11);
        step();
        chk("mux_wb_en_off", 64'(out_wb_en), 64'd0);
        chk("mux_wb_en_off_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'd0);
        step();
        chk("mux_idle_wb_en", 64'(out_wb_en), 64'd0);

        // Reset in the middle of a transfer drops everything immediately
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h70, 32'h71, 4'd12);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h72, 32'h73, 4'd13);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_alu", 64'(out_alu_res), 64'd0);
        chk("midrst_mem_r_en", 64'(out_mem_r_en), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_no_ghost", 64'(out_valid), 64'd0);

`ifdef WB_PIPE_PERF_EN
        // Stall counter: 5 stalled cycles, then saturation at 15 (CNT_W=4)
        chk("cnt_after_rst", 64'(stall_cnt), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 4'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        chk("cnt_load", 64'(stall_cnt), 64'd0);
        repeat (5) step();
        chk("cnt_five", 64'(stall_cnt), 64'd5);
        repeat (20) step();
        chk("cnt_saturate", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("cnt_flush_keeps", 64'(stall_cnt), 64'd15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
